// File: rtl/acq_serial_tx.sv
// Round-robin ADC acquisition controller with an asynchronous serial transmitter.
// Define ACQ_SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module acq_serial_tx #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 8,
    parameter int BIT_DIV     = 105,
    parameter int SETTLE_CYC  = 2,
    parameter int EOC_TIMEOUT = 1023,
    localparam int CH_W       = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              run,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              soc,
    output logic              load_dato,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              data_out,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              error,
    output logic [1:0]        err_code
);

`ifdef ACQ_SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = DATA_W + 2 + PAR_BITS;
    // Everything after the start bit waits in the shift register, stop bit last.
    localparam int SH_W  = FRAME_LEN - 1;
    localparam int DIV_W = $clog2(BIT_DIV);
    localparam int BIT_W = $clog2(FRAME_LEN);
    localparam int TO_W  = $clog2(EOC_TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DSR  = 2'b01;
    localparam logic [1:0] ERR_EOC  = 2'b10;

    typedef enum logic [2:0] {
        IDLE, SELECT, SOC, WAIT_EOC, CAPTURE, TX, NEXT
    } state_t;

    state_t            state, state_d;
    logic [SET_W-1:0]  set_cnt, set_cnt_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic [DIV_W-1:0]  div_cnt, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [SH_W-1:0]   shreg, shreg_d;
    logic [CH_W-1:0]   canale_d;
    logic              soc_d, load_dato_d, mux_en_d, data_out_d;
    logic              tx_busy_d, tx_done_d, error_d;
    logic [1:0]        err_code_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state;
        set_cnt_d  = set_cnt;
        to_cnt_d   = to_cnt;
        div_cnt_d  = div_cnt;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        canale_d   = canale;
        data_out_d = 1'b1;
        tx_done_d  = 1'b0;
        error_d    = error;
        err_code_d = err_code;

        unique case (state)
            IDLE: begin
                if (run) state_d = SELECT;
            end
            SELECT: begin
                if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    set_cnt_d = '0;
                    state_d   = SOC;
                end else begin
                    set_cnt_d = set_cnt + SET_W'(1);
                end
            end
            SOC: begin
                to_cnt_d = '0;
                state_d  = WAIT_EOC;
            end
            WAIT_EOC: begin
                // A conversion finishing on the last allowed cycle still counts.
                if (eoc) begin
`ifdef ACQ_SERIAL_TX_PARITY_EN
                    shreg_d = {data_in, ^data_in, 1'b1};
`else
                    shreg_d = {data_in, 1'b1};
`endif
                    to_cnt_d = '0;
                    state_d  = CAPTURE;
                end else if (to_cnt == TO_W'(EOC_TIMEOUT - 1)) begin
                    to_cnt_d   = '0;
                    error_d    = 1'b1;
                    err_code_d = ERR_EOC;
                    state_d    = NEXT;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            CAPTURE: begin
                if (dsr) begin
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    data_out_d = 1'b0;
                    state_d    = TX;
                end else begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DSR;
                    state_d    = NEXT;
                end
            end
            TX: begin
                data_out_d = data_out;
                if (div_cnt == DIV_W'(BIT_DIV - 1)) begin
                    div_cnt_d = '0;
                    if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                        data_out_d = 1'b1;
                        tx_done_d  = 1'b1;
                        error_d    = 1'b0;
                        err_code_d = ERR_NONE;
                        state_d    = NEXT;
                    end else begin
                        bit_cnt_d  = bit_cnt + BIT_W'(1);
                        data_out_d = shreg[SH_W-1];
                        shreg_d    = {shreg[SH_W-2:0], 1'b1};
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            NEXT: begin
                canale_d = (canale == CH_W'(NUM_CH - 1)) ? '0 : canale + CH_W'(1);
                state_d  = run ? SELECT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so the registered outputs line up with it.
        soc_d       = (state_d == SOC);
        mux_en_d    = (state_d == SELECT) || (state_d == SOC) || (state_d == WAIT_EOC);
        load_dato_d = (state_d == CAPTURE);
        tx_busy_d   = (state_d == TX);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            set_cnt   <= '0;
            to_cnt    <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            canale    <= '0;
            soc       <= 1'b0;
            load_dato <= 1'b0;
            mux_en    <= 1'b0;
            data_out  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_d;
            set_cnt   <= set_cnt_d;
            to_cnt    <= to_cnt_d;
            div_cnt   <= div_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            canale    <= canale_d;
            soc       <= soc_d;
            load_dato <= load_dato_d;
            mux_en    <= mux_en_d;
            data_out  <= data_out_d;
            tx_busy   <= tx_busy_d;
            tx_done   <= tx_done_d;
            error     <= error_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_acq_serial_tx.sv
// Bench for acq_serial_tx: an ADC responder drives per-channel transactions and
// each one is compared with the frame and status expected from its data/dsr/delay.
module tb_acq_serial_tx;

    localparam int NUM_CH      = 3;
    localparam int DATA_W      = 8;
    localparam int BIT_DIV     = 4;
    localparam int SETTLE_CYC  = 2;
    localparam int EOC_TIMEOUT = 16;
    localparam int CH_W        = 2;
`ifdef ACQ_SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_LEN = DATA_W + 2 + PAR_BITS;
    localparam int TX_CYC    = FRAME_LEN * BIT_DIV;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_RESET  = 1;
    localparam int MODE_DROP   = 2;

    logic              clock;
    logic              reset_n;
    logic              run;
    logic              eoc;
    logic [DATA_W-1:0] data_in;
    logic              dsr;
    logic              soc;
    logic              load_dato;
    logic              mux_en;
    logic [CH_W-1:0]   canale;
    logic              data_out;
    logic              tx_busy;
    logic              tx_done;
    logic              error;
    logic [1:0]        err_code;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ch   = 0;

    acq_serial_tx #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .BIT_DIV     (BIT_DIV),
        .SETTLE_CYC  (SETTLE_CYC),
        .EOC_TIMEOUT (EOC_TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .eoc       (eoc),
        .data_in   (data_in),
        .dsr       (dsr),
        .soc       (soc),
        .load_dato (load_dato),
        .mux_en    (mux_en),
        .canale    (canale),
        .data_out  (data_out),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .error     (error),
        .err_code  (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // Frame bit i: start 0, data MSB first, optional even parity, stop 1.
    function automatic logic frame_bit(input logic [DATA_W-1:0] d, input int i);
        int ones;
        if (i == 0) return 1'b0;
        if (i <= DATA_W) return d[DATA_W-i];
        if (PAR_BITS == 1 && i == DATA_W + 1) begin
            ones = 0;
            for (int j = 0; j < DATA_W; j++) if (d[j]) ones++;
            return (ones % 2) == 1;
        end
        return 1'b1;
    endfunction

    task automatic run_channel(input int delay, input logic [DATA_W-1:0] data,
                               input bit dsr_v, input int mode);
        int   cnt;
        int   busy;
        int   same;
        bit   found;
        bit   captured;
        logic smp [TX_CYC];
        dsr = dsr_v;

        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick;
            if (mux_en) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            check("select_seen", 32'(0), 32'(1));
            return;
        end
        check("canale", 32'(canale), 32'(exp_ch));

        cnt = 0;
        while (mux_en && !soc && cnt < 50) begin
            cnt++;
            tick;
        end
        check("settle_cycles", 32'(cnt), 32'(SETTLE_CYC));
        check("soc_high", 32'(soc), 32'(1));
        check("soc_mux_en", 32'(mux_en), 32'(1));
        tick;
        check("soc_width", 32'(soc), 32'(0));

        captured = 1'b0;
        for (int k = 0; k < EOC_TIMEOUT; k++) begin
            if (k > 0) tick;
            eoc     = (delay < EOC_TIMEOUT) && (k >= delay);
            data_in = eoc ? data : DATA_W'($urandom);
            if (eoc) begin
                captured = 1'b1;
                break;
            end
        end
        tick;
        eoc     = 1'b0;
        data_in = DATA_W'($urandom);

        if (!captured) begin
            check("timeout_no_load", 32'(load_dato), 32'(0));
            check("timeout_mux_off", 32'(mux_en), 32'(0));
            check("timeout_error", 32'(error), 32'(1));
            check("timeout_code", 32'(err_code), 32'(2));
            exp_ch = (exp_ch + 1) % NUM_CH;
            return;
        end
        check("load_dato", 32'(load_dato), 32'(1));
        check("capture_mux_off", 32'(mux_en), 32'(0));
        tick;

        if (!dsr_v) begin
            check("dsr_line_idle", 32'(data_out), 32'(1));
            check("dsr_not_busy", 32'(tx_busy), 32'(0));
            check("dsr_error", 32'(error), 32'(1));
            check("dsr_code", 32'(err_code), 32'(1));
            exp_ch = (exp_ch + 1) % NUM_CH;
            return;
        end

        busy = 0;
        for (int i = 0; i < TX_CYC; i++) begin
            if (mode == MODE_RESET && i == 3 * BIT_DIV + 1) begin
                reset_n = 1'b0;
                #1;
                check("rst_data_out", 32'(data_out), 32'(1));
                check("rst_tx_busy", 32'(tx_busy), 32'(0));
                check("rst_canale", 32'(canale), 32'(0));
                check("rst_error", 32'(error), 32'(0));
                tick;
                reset_n = 1'b1;
                exp_ch  = 0;
                return;
            end
            if (mode == MODE_DROP && i == 2 * BIT_DIV) run = 1'b0;
            smp[i] = data_out;
            if (tx_busy) busy++;
            tick;
        end
        check("tx_busy_cycles", 32'(busy), 32'(TX_CYC));
        for (int b = 0; b < FRAME_LEN; b++) begin
            same = 0;
            for (int j = 0; j < BIT_DIV; j++)
                if (smp[b*BIT_DIV+j] === frame_bit(data, b)) same++;
            check($sformatf("frame_bit%0d_data%02h", b, data), 32'(same), 32'(BIT_DIV));
        end
        check("tx_done", 32'(tx_done), 32'(1));
        check("done_not_busy", 32'(tx_busy), 32'(0));
        check("done_line_idle", 32'(data_out), 32'(1));
        check("done_error_clear", 32'(error), 32'(0));
        check("done_code_clear", 32'(err_code), 32'(0));
        exp_ch = (exp_ch + 1) % NUM_CH;

        if (mode == MODE_DROP) begin
            cnt = 0;
            for (int i = 0; i < 10; i++) begin
                tick;
                if (mux_en) cnt++;
            end
            check("idle_after_stop", 32'(cnt), 32'(0));
            check("canale_after_stop", 32'(canale), 32'(exp_ch));
            run = 1'b1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        eoc     = 1'b0;
        dsr     = 1'b1;
        data_in = '0;
        repeat (2) tick;

        check("reset_soc", 32'(soc), 32'(0));
        check("reset_load_dato", 32'(load_dato), 32'(0));
        check("reset_mux_en", 32'(mux_en), 32'(0));
        check("reset_canale", 32'(canale), 32'(0));
        check("reset_data_out", 32'(data_out), 32'(1));
        check("reset_tx_busy", 32'(tx_busy), 32'(0));
        check("reset_tx_done", 32'(tx_done), 32'(0));
        check("reset_error", 32'(error), 32'(0));
        check("reset_err_code", 32'(err_code), 32'(0));

        reset_n = 1'b1;
        repeat (5) tick;
        check("idle_without_run", 32'(mux_en), 32'(0));

        run    = 1'b1;
        exp_ch = 0;
        run_channel(3, 8'hA5, 1'b1, MODE_NORMAL);
        run_channel(0, 8'h07, 1'b1, MODE_NORMAL);
        run_channel(5, 8'h3C, 1'b1, MODE_NORMAL);
        run_channel(2, 8'h5A, 1'b0, MODE_NORMAL);
        run_channel(1, 8'hFF, 1'b1, MODE_NORMAL);
        run_channel(EOC_TIMEOUT, 8'h11, 1'b1, MODE_NORMAL);
        run_channel(EOC_TIMEOUT - 1, 8'h80, 1'b1, MODE_NORMAL);
        run_channel(4, 8'h00, 1'b0, MODE_NORMAL);
        run_channel(2, 8'hC3, 1'b1, MODE_RESET);
        run_channel(1, 8'h96, 1'b1, MODE_NORMAL);
        run_channel(2, 8'h0F, 1'b1, MODE_DROP);
        for (int n = 0; n < 14; n++) begin
            run_channel(int'($urandom_range(0, EOC_TIMEOUT + 3)), DATA_W'($urandom),
                        $urandom_range(0, 3) != 0, MODE_NORMAL);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
